// File: rtl/div_unit_pkg.sv
// Shared constants and types for the iterative MIPS divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  typedef logic [5:0]  div_cnt_t;
  typedef logic [31:0] reg_bus_t;

  localparam reg_bus_t ZERO_WORD     = 32'h0000_0000;
  localparam reg_bus_t DIV_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam div_cnt_t DIV_LAST_CNT  = 6'd31;

  // Two's complement negate when neg is set (modulo 2^32).
  function automatic reg_bus_t cond_neg(input reg_bus_t v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step: compare/subtract divisor from the shifted partial remainder.
module div_step
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   partial_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  // When the subtraction succeeds the difference is below the divisor,
  // so a WIDTH-bit subtract is exact.
  always_comb begin
    qbit_o = (partial_i >= {1'b0, divisor_i});
    rem_o  = qbit_o ? (partial_i[WIDTH-1:0] - divisor_i) : partial_i[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 DIV/DIVU unit feeding the HI/LO register pair.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             cancel_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  div_state_e         state_q, state_d;
  div_cnt_t           cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   step_rem;
  logic               step_qbit;
  logic [WIDTH-1:0]   quot_raw;

  div_step #(.WIDTH(WIDTH)) u_step (
    .partial_i (work_q[2*WIDTH-1:WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  assign quot_raw = {work_q[WIDTH-2:0], step_qbit};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    dvs_d      = dvs_q;
    dvd_d      = dvd_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      DIV_FREE: begin
        if (start_i && !cancel_i) begin
          neg_quot_d = signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
          neg_rem_d  = signed_i && dividend_i[WIDTH-1];
          dvs_d      = cond_neg(divisor_i, signed_i && divisor_i[WIDTH-1]);
          dvd_d      = dividend_i;
          work_d     = {ZERO_WORD, cond_neg(dividend_i, signed_i && dividend_i[WIDTH-1])};
          cnt_d      = '0;
          state_d    = (divisor_i == ZERO_WORD) ? DIV_BY_ZERO : DIV_ON;
        end
      end
      DIV_ON: begin
        work_d = {step_rem, quot_raw};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == DIV_LAST_CNT) begin
          state_d = DIV_END;
          hi_d    = cond_neg(step_rem, neg_rem_q);
          lo_d    = cond_neg(quot_raw, neg_quot_q);
        end
      end
      DIV_BY_ZERO: begin
        state_d = DIV_END;
        hi_d    = dvd_q;
        lo_d    = DIV_ZERO_QUOT;
      end
      DIV_END: state_d = DIV_FREE;
      default: state_d = DIV_FREE;
    endcase

    // A flush discards the result too, so HI/LO never see a partial update.
    if (cancel_i) begin
      state_d = DIV_FREE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      work_q     <= '0;
      dvs_q      <= '0;
      dvd_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      dvs_q      <= dvs_d;
      dvd_q      <= dvd_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign stall_o = ((state_q == DIV_FREE) && start_i && !cancel_i)
                 || (state_q == DIV_ON) || (state_q == DIV_BY_ZERO);
  assign busy_o  = (state_q != DIV_FREE);
  assign we_o    = (state_q == DIV_END) && !cancel_i;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: result table plus cancel/reset/collision sequences.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, signed_i, cancel_i;
  logic [31:0] dividend_i, divisor_i;
  logic        stall_o, busy_o, we_o;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .cancel_i    (cancel_i),
    .stall_o     (stall_o),
    .busy_o      (busy_o),
    .we_o        (we_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Enter just after a rising edge; leaves just after the edge following the first IDLE cycle.
  task automatic run_op(input vec_t v);
    int          we_cyc;
    int          we_cnt;
    logic [31:0] hcap, lcap;
    we_cyc = -1; we_cnt = 0; hcap = '0; lcap = '0;
    signed_i = v.sgn; dividend_i = v.a; divisor_i = v.b; start_i = 1'b1;
    for (int c = 0; c <= v.lat + 1; c++) begin
      @(negedge clk);
      check($sformatf("%s stall c%0d", v.name, c), {31'b0, stall_o}, {31'b0, (c < v.lat)});
      if (we_o) begin
        if (we_cyc < 0) we_cyc = c;
        we_cnt++;
        hcap = hi_o; lcap = lo_o;
      end
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    check({v.name, " we cycle"}, we_cyc, v.lat);
    check({v.name, " we count"}, we_cnt, 1);
    check({v.name, " hi"}, hcap, v.exp_hi);
    check({v.name, " lo"}, lcap, v.exp_lo);
  endtask

  initial begin
    int we_seen;
    vecs[0] = '{"divu 100/7",   1'b0, 32'd100,      32'd7,        33, 32'd2,        32'd14};
    vecs[1] = '{"div -7/2",     1'b1, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2] = '{"div min/-1",   1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0,        32'h80000000};
    vecs[3] = '{"divu ffff/16", 1'b0, 32'hFFFFFFFF, 32'h10,       33, 32'hF,        32'h0FFFFFFF};
    vecs[4] = '{"div -1/16",    1'b1, 32'hFFFFFFFF, 32'h10,       33, 32'hFFFFFFFF, 32'd0};
    vecs[5] = '{"div 7/-2",     1'b1, 32'd7,        32'hFFFFFFFE, 33, 32'd1,        32'hFFFFFFFD};
    vecs[6] = '{"divu 3/5",     1'b0, 32'd3,        32'd5,        33, 32'd3,        32'd0};
    vecs[7] = '{"div 5/0",      1'b1, 32'd5,        32'd0,        2,  32'd5,        32'hFFFFFFFF};

    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; cancel_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy",  {31'b0, busy_o},  32'd0);
    check("reset stall", {31'b0, stall_o}, 32'd0);
    check("reset we",    {31'b0, we_o},    32'd0);
    check("reset hi",    hi_o, 32'd0);
    check("reset lo",    lo_o, 32'd0);
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i]);

    // Cancel in cycle 10 of DIVU 100/7; HI/LO stay at the 5/0 result.
    we_seen = 0;
    signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      cancel_i = (c == 10);
      @(negedge clk);
      if (we_o) we_seen++;
      if (c == 11) begin
        check("cancel busy next", {31'b0, busy_o},  32'd0);
        check("cancel stall next", {31'b0, stall_o}, 32'd0);
        check("cancel hi held", hi_o, 32'd5);
        check("cancel lo held", lo_o, 32'hFFFFFFFF);
      end
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    cancel_i = 1'b0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (we_o) we_seen++;
      @(posedge clk); #1;
    end
    check("cancel no we", we_seen, 0);
    check("cancel still idle", {31'b0, busy_o}, 32'd0);

    // Cancel-then-restart timing: start in cycle 12 relative to the aborted op.
    signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      cancel_i = (c == 10);
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    cancel_i = 1'b0;
    run_op('{"divu 9/3 after cancel", 1'b0, 32'd9, 32'd3, 33, 32'd0, 32'd3});

    // start and cancel together in IDLE: nothing launches.
    signed_i = 1'b0; dividend_i = 32'd50; divisor_i = 32'd5; start_i = 1'b1; cancel_i = 1'b1;
    @(negedge clk);
    check("start+cancel stall", {31'b0, stall_o}, 32'd0);
    check("start+cancel we", {31'b0, we_o}, 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0; cancel_i = 1'b0;
    @(negedge clk);
    check("start+cancel busy", {31'b0, busy_o}, 32'd0);
    @(posedge clk); #1;

    // Reset in cycle 20 with start held; outputs clear and nothing launches.
    signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 1; c < 20; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; start_i = 1'b1;
    @(negedge clk);
    check("pre-reset busy", {31'b0, busy_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("post-reset busy",  {31'b0, busy_o},  32'd0);
    check("post-reset stall", {31'b0, stall_o}, 32'd0);
    check("post-reset we",    {31'b0, we_o},    32'd0);
    check("post-reset hi",    hi_o, 32'd0);
    check("post-reset lo",    lo_o, 32'd0);
    we_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (we_o || busy_o) we_seen++;
    end
    check("post-reset quiet", we_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
